// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake between the CPU io-write path and the buffered UART transmitter.
// The master pushes w_data with w_en; the slave reports free space on w_ready.
interface uart_tx_buffered_if;
  logic       w_en;
  logic [7:0] w_data;
  logic       w_ready;

  modport master (output w_en, output w_data, input  w_ready);
  modport slave  (input  w_en, input  w_data, output w_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO feeding a serialiser that holds
// each bit for WAIT clocks, with a sticky drained interrupt and a sticky overflow flag.
module uart_tx_buffered #(
  parameter int WAIT  = 868,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_buffered_if.slave   wr,
  output logic                tx_busy,
  output logic                tx_irr,
  input  logic                irr_ack,
  output logic                overflow,
  output logic                uart_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WAIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          irr_q;

  logic push, pop, baud_done, fifo_nonempty;

  assign wr.w_ready    = (count_q != CW'(DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign push          = wr.w_en && wr.w_ready;
  assign baud_done     = (baud_q == BW'(WAIT - 1));
  // The serialiser takes a byte from IDLE, or straight out of the last stop-bit clock.
  assign pop = fifo_nonempty && ((state_q == IDLE) || (state_q == STOP && baud_done));

  assign tx_busy  = (state_q != IDLE) || fifo_nonempty;
  assign tx_irr   = irr_q;
  assign overflow = overflow_q;
  assign uart_tx  = tx_q;

  // NOTE: all state flops use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (wr.w_en && !wr.w_ready) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr.w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irr_q   <= 1'b0;
    end else begin
      // Ack clears first so a drain on the same edge overrides it below.
      if (irr_ack) irr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_q];
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              irr_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
